trigger_capture_buffer: RTL and testbench

//  Sits downstream of mcp3008_adc and the min/max transmission detector, and upstream of the UART/SD dump path.

---
 rtl/capture_pkg.sv | 23 ++
 rtl/capture_ram.sv | 27 ++
 rtl/trigger_capture_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_trigger_capture_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types for the trigger capture buffer.
// Holds the FSM state encoding and the stream handshake helpers.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    DRAIN
  } capture_state_t;

  localparam logic HS_VALID = 1'b1;
  localparam logic HS_READY = 1'b1;

  function automatic logic xfer(
    input logic v,
    input logic r
  );
    return (v == HS_VALID) && (r == HS_READY);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM.
// One write port, one read port with a registered read.
module capture_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write and registered read, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Circular pre/post trigger sample capture.
// Records history, captures around a trigger and streams the window out.
module trigger_capture_buffer
  import capture_pkg::*;
#(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int DEPTH             = 256,
  parameter int PRE_TRIGGER       = 64,
  parameter int POST_TRIGGER      = 192
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         axiiv,
  input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
  input  logic                         trigger,
  input  logic                         arm,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  input  logic                         axiord,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int W  = SAMPLE_DATA_WIDTH;

  localparam logic [CW-1:0] PRE_C  = CW'(PRE_TRIGGER);
  localparam logic [CW-1:0] POST_C = CW'(POST_TRIGGER);
  localparam logic [CW-1:0] TOT_C  =
    CW'(PRE_TRIGGER + POST_TRIGGER);
  localparam logic [CW-1:0] LAST_C =
    CW'(PRE_TRIGGER + POST_TRIGGER - 1);
  localparam logic [AW-1:0] PRE_A  = AW'(PRE_TRIGGER);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  capture_state_t state;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fill;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] iss_cnt;

  logic          rv;
  logic          sv;
  logic [W-1:0]  sd;
  logic [W-1:0]  ram_q;

  logic          we;
  logic          pop;
  logic          issue;
  logic [2:0]    occ;

  // Only the capture states write, every accepted ADC strobe.
  assign we = axiiv &&
    (state == PREFILL ||
     state == ARMED ||
     state == POST);

  assign pop = xfer(axiov, axiord);

  // Entries that will be held after this edge: output reg,
  // skid reg and the read in flight. A new read is only issued
  // when its data is guaranteed a slot next cycle.
  assign occ = 3'(axiov) + 3'(sv) + 3'(rv) - 3'(pop);

  assign issue = (state == DRAIN) && !done &&
    (iss_cnt != TOT_C) && (occ <= 3'd1);

  capture_ram #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (axiid),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Capture FSM with pointers, counters, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      trig_ptr <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      post_cnt <= '0;
      out_cnt  <= '0;
      iss_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arm) begin
            state <= PREFILL;
            fill  <= '0;
            busy  <= 1'b1;
          end
        end
        PREFILL: begin
          if (axiiv) begin
            wr_ptr <= wr_ptr + 1'b1;
            fill   <= fill + ONE_C;
            if (fill + ONE_C == PRE_C)
              state <= ARMED;
          end
        end
        ARMED: begin
          if (axiiv)
            wr_ptr <= wr_ptr + 1'b1;
          if (trigger) begin
            trig_ptr <= wr_ptr;
            post_cnt <= axiiv ? ONE_C : '0;
            if (axiiv && POST_C == ONE_C) begin
              state   <= DRAIN;
              rd_ptr  <= wr_ptr - PRE_A;
              out_cnt <= '0;
              iss_cnt <= '0;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (axiiv) begin
            wr_ptr   <= wr_ptr + 1'b1;
            post_cnt <= post_cnt + ONE_C;
            if (post_cnt + ONE_C == POST_C) begin
              state   <= DRAIN;
              rd_ptr  <= trig_ptr - PRE_A;
              out_cnt <= '0;
              iss_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (pop) begin
              out_cnt <= out_cnt + ONE_C;
              if (out_cnt == LAST_C)
                done <= 1'b1;
            end
            if (issue) begin
              rd_ptr  <= rd_ptr + 1'b1;
              iss_cnt <= iss_cnt + ONE_C;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register plus skid register hiding the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv    <= 1'b0;
      sv    <= 1'b0;
      sd    <= '0;
      axiov <= 1'b0;
      axiod <= '0;
    end else begin
      rv <= issue;
      if (!axiov || pop) begin
        if (sv) begin
          axiov <= 1'b1;
          axiod <= sd;
          if (rv)
            sd <= ram_q;
          else
            sv <= 1'b0;
        end else if (rv) begin
          axiov <= 1'b1;
          axiod <= ram_q;
        end else begin
          axiov <= 1'b0;
        end
      end else if (rv) begin
        sv <= 1'b1;
        sd <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Bench for trigger_capture_buffer.
// Table of capture scenarios plus a mid-drain reset sequence.
module tb_trigger_capture_buffer;

  localparam int W    = 8;
  localparam int DEP  = 16;
  localparam int PRE  = 4;
  localparam int POST = 8;
  localparam int TOT  = PRE + POST;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         axiiv = 1'b0;
  logic [W-1:0] axiid = '0;
  logic         trigger = 1'b0;
  logic         arm = 1'b0;
  logic         axiov;
  logic [W-1:0] axiod;
  logic         axiord = 1'b1;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  bit bp = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_d = '0;
  int exp_q[$];

  typedef struct {
    int first;
    int trig;
    int pretrig;
    bit gap;
    bit bp;
    int exp_first;
  } vec_t;

  vec_t vecs[6];

  trigger_capture_buffer #(
    .SAMPLE_DATA_WIDTH (W),
    .DEPTH             (DEP),
    .PRE_TRIGGER       (PRE),
    .POST_TRIGGER      (POST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .axiiv   (axiiv),
    .axiid   (axiid),
    .trigger (trigger),
    .arm     (arm),
    .axiov   (axiov),
    .axiod   (axiod),
    .axiord  (axiord),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Downstream ready, random when backpressure is enabled.
  always @(posedge clk) begin
    #1;
    axiord = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard pop on handshake, stability on stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(axiov), 1);
        chk("stall_data", int'(axiod), int'(prev_d));
      end
      if (axiov && axiord) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", int'(axiod), -1);
        end else begin
          chk("out_data", int'(axiod), exp_q.pop_front());
        end
      end
      prev_stall = axiov && !axiord;
      prev_d = axiod;
    end
  end

  task automatic drive(input bit v, input int d, input bit t);
    @(posedge clk);
    #1;
    axiiv = v;
    axiid = W'(d);
    trigger = t;
  endtask

  task automatic push_exp(input int f);
    for (int i = 0; i < TOT; i++)
      exp_q.push_back((f + i) & 255);
  endtask

  task automatic do_arm();
    chk("busy_before_arm", int'(busy), 0);
    @(posedge clk);
    #1;
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    chk("busy_after_arm", int'(busy), 1);
  endtask

  task automatic feed(input int first, input int trig,
                      input int pretrig, input bit gap);
    int v;
    v = first;
    while (v <= trig + POST - 1) begin
      if (gap && v == trig)
        drive(1'b0, 0, 1'b1);
      drive(1'b1, v, (!gap && v == trig) || v == pretrig);
      v++;
    end
    for (int k = 0; k < 3; k++)
      drive(1'b1, 250 + k, 1'b1);
    drive(1'b0, 0, 1'b0);
  endtask

  task automatic finish_capture();
    int n;
    int extra;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 600);
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("busy_at_done", int'(busy), 1);
      chk("valid_at_done", int'(axiov), 0);
    end
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done)
        extra++;
    end
    chk("done_extra_pulses", extra, 0);
    chk("busy_after_done", int'(busy), 0);
    chk("queue_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int base;

    vecs[0] = '{first: 0,   trig: 20,  pretrig: -1,
                gap: 0, bp: 0, exp_first: 16};
    vecs[1] = '{first: 0,   trig: 10,  pretrig: 2,
                gap: 0, bp: 0, exp_first: 6};
    vecs[2] = '{first: 0,   trig: 45,  pretrig: -1,
                gap: 0, bp: 0, exp_first: 41};
    vecs[3] = '{first: 0,   trig: 20,  pretrig: -1,
                gap: 0, bp: 1, exp_first: 16};
    vecs[4] = '{first: 100, trig: 110, pretrig: -1,
                gap: 1, bp: 0, exp_first: 106};
    vecs[5] = '{first: 50,  trig: 57,  pretrig: -1,
                gap: 0, bp: 1, exp_first: 53};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_axiov", int'(axiov), 0);
    chk("rst_axiod", int'(axiod), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    for (int i = 0; i < 6; i++) begin
      bp = vecs[i].bp;
      push_exp(vecs[i].exp_first);
      do_arm();
      feed(vecs[i].first, vecs[i].trig,
           vecs[i].pretrig, vecs[i].gap);
      finish_capture();
      bp = 1'b0;
    end

    bp = 1'b0;
    push_exp(16);
    do_arm();
    base = hs_cnt;
    feed(0, 20, -1, 1'b0);
    n = 0;
    while (hs_cnt < base + 5 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("pre_reset_count", hs_cnt - base, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_axiov", int'(axiov), 0);
    chk("midrst_axiod", int'(axiod), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push_exp(16);
    do_arm();
    feed(0, 20, -1, 1'b0);
    finish_capture();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
